configregpwm_pack: RTL and testbench

- Write-side counterpart of the PWM config-register field split. Collects typed PWM config fields from the AXI register front-end through a valid/ready handshake and packs them into a shadow word.
- Commits the shadow word to the active config word register_concat either immediately or at the next PWM period boundary (sync_evt), so mode changes never tear a PWM period.
- Sits between the AXI4-Lite slave register file and the PWM core's field-split/decoder.

---
 rtl/configregpwm_pack.sv | 96 +++++++++
 tb/tb_configregpwm_pack.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/configregpwm_pack.sv
// Packs typed PWM config fields into a shadow word and commits it to the active
// config word either immediately or at the next PWM period boundary.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module configregpwm_pack #(
  parameter int REG_WIDTH = `PWMCOUNT_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 upd_mode,
  input  logic [1:0]           count_mode,
  input  logic [1:0]           mask_mode,
  input  logic                 pwmclkdiv_onoff,
  input  logic                 dtclkdiv_onoff,
  input  logic                 int_onoff,
  input  logic                 pwm_onoff,
  input  logic                 logic_A,
  input  logic                 logic_B,
  input  logic                 sync_evt,
  input  logic                 cfg_flush,
  input  logic                 ovr_clr,
  output logic [REG_WIDTH-1:0] register_concat,
  output logic [REG_WIDTH-1:0] shadow_concat,
  output logic                 pending,
  output logic                 upd_done,
  output logic                 ovr,
  output logic [CNT_WIDTH-1:0] commit_cnt
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t               state, state_nxt;
  logic [REG_WIDTH-1:0] packed_word;
  logic                 accept, immediate, commit_sync, commit;

  always_comb begin
    packed_word      = '0;
    packed_word[9:0] = {logic_B, logic_A, pwm_onoff, int_onoff, dtclkdiv_onoff,
                        pwmclkdiv_onoff, mask_mode, count_mode};
  end

  // Switching the PWM off never waits for a period boundary.
  assign immediate = upd_mode | ~pwm_onoff;

  always_comb begin
    state_nxt   = state;
    cfg_ready   = 1'b0;
    accept      = 1'b0;
    commit_sync = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = ~rst;
        accept    = cfg_valid & ~rst;
        if (accept && !immediate) state_nxt = ARMED;
      end
      ARMED: begin
        // flush beats a coincident period boundary
        if (cfg_flush) state_nxt = IDLE;
        else if (sync_evt) begin
          commit_sync = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit  = (accept & immediate) | commit_sync;
  assign pending = (state == ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      register_concat <= '0;
      shadow_concat   <= '0;
      upd_done        <= 1'b0;
      ovr             <= 1'b0;
      commit_cnt      <= '0;
    end else begin
      state    <= state_nxt;
      upd_done <= commit;
      if (accept) shadow_concat <= packed_word;
      if (accept && immediate) register_concat <= packed_word;
      else if (commit_sync)    register_concat <= shadow_concat;
      if (commit && commit_cnt != {CNT_WIDTH{1'b1}}) commit_cnt <= commit_cnt + 1'b1;
      if (cfg_valid && !cfg_ready) ovr <= 1'b1;
      else if (ovr_clr)            ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_configregpwm_pack.sv
// Directed bench for configregpwm_pack: behavioural model checked every cycle
// plus hand-computed literal expectations.
module tb_configregpwm_pack;
  localparam int RW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_ready, upd_mode;
  logic [1:0]    count_mode, mask_mode;
  logic          pwmclkdiv_onoff, dtclkdiv_onoff, int_onoff, pwm_onoff, logic_A, logic_B;
  logic          sync_evt, cfg_flush, ovr_clr;
  logic [RW-1:0] register_concat, shadow_concat;
  logic          pending, upd_done, ovr;
  logic [CW-1:0] commit_cnt;

  configregpwm_pack #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .upd_mode(upd_mode), .count_mode(count_mode), .mask_mode(mask_mode),
    .pwmclkdiv_onoff(pwmclkdiv_onoff), .dtclkdiv_onoff(dtclkdiv_onoff),
    .int_onoff(int_onoff), .pwm_onoff(pwm_onoff), .logic_A(logic_A), .logic_B(logic_B),
    .sync_evt(sync_evt), .cfg_flush(cfg_flush), .ovr_clr(ovr_clr),
    .register_concat(register_concat), .shadow_concat(shadow_concat),
    .pending(pending), .upd_done(upd_done), .ovr(ovr), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must be, from the rules.
  int m_active, m_shadow, m_cnt;
  bit m_pending, m_done, m_ovr, m_en;

  function automatic int pack_fields();
    return count_mode + 4 * mask_mode + 16 * pwmclkdiv_onoff + 32 * dtclkdiv_onoff
         + 64 * int_onoff + 128 * pwm_onoff + 256 * logic_A + 512 * logic_B;
  endfunction

  function automatic int sat_inc(input int c);
    return (c + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_shadow = 0; m_pending = 0; m_done = 0; m_ovr = 0; m_cnt = 0; m_en = 1;
    end else if (m_en) begin
      bit was_pending;
      was_pending = m_pending;
      m_done = 0;
      if (cfg_valid && was_pending) m_ovr = 1;
      else if (ovr_clr)             m_ovr = 0;
      if (was_pending) begin
        if (cfg_flush) m_pending = 0;
        else if (sync_evt) begin
          m_active = m_shadow; m_pending = 0; m_done = 1; m_cnt = sat_inc(m_cnt);
        end
      end else if (cfg_valid) begin
        m_shadow = pack_fields();
        if (upd_mode || !pwm_onoff) begin
          m_active = m_shadow; m_done = 1; m_cnt = sat_inc(m_cnt);
        end else m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("cfg_ready", int'(cfg_ready), int'(!rst && !m_pending));
      chk("register_concat", int'(register_concat), m_active);
      chk("shadow_concat", int'(shadow_concat), m_shadow);
      chk("pending", int'(pending), int'(m_pending));
      chk("upd_done", int'(upd_done), int'(m_done));
      chk("ovr", int'(ovr), int'(m_ovr));
      chk("commit_cnt", int'(commit_cnt), m_cnt);
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [9:0] w, input logic um);
    cfg_valid = 1'b1; upd_mode = um;
    count_mode = w[1:0]; mask_mode = w[3:2];
    pwmclkdiv_onoff = w[4]; dtclkdiv_onoff = w[5]; int_onoff = w[6];
    pwm_onoff = w[7]; logic_A = w[8]; logic_B = w[9];
  endtask

  task automatic idle();
    cfg_valid = 0; sync_evt = 0; cfg_flush = 0; ovr_clr = 0;
  endtask

  initial begin
    rst = 1; idle(); offer(10'h0, 1'b0); cfg_valid = 0;
    next(); next();
    chk("rst register", int'(register_concat), 0);
    chk("rst ready", int'(cfg_ready), 0);
    chk("rst cnt", int'(commit_cnt), 0);
    rst = 0;
    next();
    chk("ready after rst", int'(cfg_ready), 1);

    // immediate write
    offer(10'h189, 1'b1); next();
    chk("imm register", int'(register_concat), 'h189);
    chk("imm done", int'(upd_done), 1);
    chk("imm cnt", int'(commit_cnt), 1);
    idle(); next();
    chk("imm done drop", int'(upd_done), 0);

    // sync write; coincident sync_evt on acceptance edge is ignored
    offer(10'h0A3, 1'b0); sync_evt = 1; next();
    idle();
    chk("sync pending", int'(pending), 1);
    chk("sync ready", int'(cfg_ready), 0);
    chk("sync reg held", int'(register_concat), 'h189);
    for (int i = 0; i < 5; i++) next();
    chk("sync reg held 5", int'(register_concat), 'h189);
    sync_evt = 1; next(); idle();
    chk("sync register", int'(register_concat), 'h0A3);
    chk("sync done", int'(upd_done), 1);
    chk("sync pending clr", int'(pending), 0);
    chk("sync cnt", int'(commit_cnt), 2);
    next();

    // flush vs sync on the same edge
    offer(10'h0C0, 1'b0); next(); idle();
    cfg_flush = 1; sync_evt = 1; next(); idle();
    chk("flush register", int'(register_concat), 'h0A3);
    chk("flush done", int'(upd_done), 0);
    chk("flush pending", int'(pending), 0);
    chk("flush cnt", int'(commit_cnt), 2);
    chk("flush shadow", int'(shadow_concat), 'h0C0);
    cfg_flush = 1; next(); idle();   // flush in IDLE is harmless

    // force-off
    offer(10'h083, 1'b1); next();
    offer(10'h003, 1'b0); next(); idle();
    chk("off register", int'(register_concat), 'h003);
    chk("off pending", int'(pending), 0);
    chk("off cnt sat", int'(commit_cnt), 3);

    // overrun while armed
    offer(10'h0A3, 1'b0); next();
    offer(10'h3FF, 1'b1); next();
    chk("ovr set", int'(ovr), 1);
    chk("ovr shadow", int'(shadow_concat), 'h0A3);
    ovr_clr = 1; next();
    chk("ovr set wins", int'(ovr), 1);
    idle(); ovr_clr = 1; next(); idle();
    chk("ovr clr", int'(ovr), 0);
    chk("ovr still pending", int'(pending), 1);

    // reset while armed, then sync_evt must not commit
    rst = 1; next(); rst = 0;
    chk("rst armed pending", int'(pending), 0);
    chk("rst armed register", int'(register_concat), 0);
    chk("rst armed shadow", int'(shadow_concat), 0);
    sync_evt = 1; next(); idle();
    chk("post rst sync", int'(register_concat), 0);
    chk("post rst done", int'(upd_done), 0);

    // back-to-back immediate commits, saturation
    for (int i = 0; i < 5; i++) begin
      offer(10'(i * 37 + 1) | 10'h080, 1'b1); next();
      chk("b2b done", int'(upd_done), 1);
    end
    idle(); next();
    chk("sat cnt", int'(commit_cnt), 3);

    // mixed directed sweep against the model
    for (int i = 0; i < 12; i++) begin
      offer(10'(i * 83 + 5), 1'(i % 3 == 0));
      sync_evt = 1'(i % 4 == 1); cfg_flush = 1'(i % 5 == 2); ovr_clr = 1'(i % 2);
      next(); idle(); next();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
